// File: rtl/dmem_sram_like_bridge_pkg.sv
// Shared definitions for the data-side SRAM-like bridge: FSM states, access
// size codes and the captured request record.
package dmem_sram_like_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } dmem_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // kseg0 (100) and kseg1 (101) both live in the 0x8000_0000-0xBFFF_FFFF window
  function automatic logic is_unmapped_seg(input logic [31:0] va);
    return (va[31:30] == 2'b10);
  endfunction

endpackage

// File: rtl/dmem_addr_map.sv
// Fixed virtual-to-physical map: kseg0/kseg1 drop bits [31:29], all other
// segments pass through. Shared with the instruction-side bridge.
module dmem_addr_map
  import dmem_sram_like_bridge_pkg::*;
(
  input  logic [31:0] i_vaddr,
  output logic [31:0] o_paddr
);

  logic w_unmapped;

  assign w_unmapped = is_unmapped_seg(i_vaddr);
  assign o_paddr    = w_unmapped ? {3'b000, i_vaddr[28:0]} : i_vaddr;

endmodule

// File: rtl/dmem_sram_like_bridge.sv
// MEM-stage data access to SRAM-like bus bridge. One bus transaction per CPU
// access; the pipeline is stalled until data_ok returns.
module dmem_sram_like_bridge
  import dmem_sram_like_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_hold,
  output logic [31:0] cpu_rdata,
  output logic        stallreq_o,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  dmem_state_e r_state;
  dmem_req_t   r_req;
  logic [31:0] r_rdata_q;

  dmem_req_t   w_req;
  dmem_req_t   w_out;
  logic [31:0] w_paddr;
  logic        w_resp;

  dmem_addr_map u_addr_map (
    .i_vaddr (cpu_addr),
    .o_paddr (w_paddr)
  );

  assign w_req.wr    = cpu_we;
  assign w_req.size  = cpu_size;
  assign w_req.addr  = w_paddr;
  assign w_req.wdata = cpu_wdata;

  // data_ok only completes a transaction once the address phase is over
  assign w_resp = (r_state == ST_DATA) && data_data_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_req     <= '0;
      r_rdata_q <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_en) begin
            r_req   <= w_req;
            r_state <= data_addr_ok ? ST_DATA : ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (data_addr_ok) r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (data_data_ok) begin
            r_rdata_q <= data_rdata;
            r_state   <= cpu_hold ? ST_DONE : ST_IDLE;
          end
        end
        ST_DONE: begin
          // result is held here so a frozen MEM stage does not reissue the access
          if (!cpu_hold) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_out      = (r_state == ST_IDLE) ? w_req : r_req;
    data_req   = 1'b0;
    stallreq_o = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          data_req   = cpu_en;
          stallreq_o = cpu_en;
        end
        ST_ADDR: begin
          data_req   = 1'b1;
          stallreq_o = 1'b1;
        end
        ST_DATA: begin
          data_req   = 1'b0;
          stallreq_o = ~data_data_ok;
        end
        default: begin
          data_req   = 1'b0;
          stallreq_o = 1'b0;
        end
      endcase
    end
  end

  assign data_wr    = w_out.wr;
  assign data_size  = w_out.size;
  assign data_addr  = w_out.addr;
  assign data_wdata = w_out.wdata;
  assign cpu_rdata  = w_resp ? data_rdata : r_rdata_q;

endmodule
